fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter / instruction-fetch stage directly downstream of the control decoder.
//  Consumes the decoder's Branch, BranchEn, PCTarg and Ack outputs plus the ALU condition flag.
//  Produces ProgCtr, the instruction-ROM address for the next cycle's fetch.
//  Runs a Start/Done FSM that arms, runs and halts one program per Start pulse.
// PARAMETERS
//  PC_W       10   width of ProgCtr (instruction ROM depth = 2**PC_W)
//  START_ADDR 0    PC value loaded on reset and on Start
//  LUT_DEPTH  64   absolute-target LUT entries; indexed by PCTarg[5:0]
// PORTS
//  Clk        in   1     system clock; all state updates on posedge
//  Reset      in   1     synchronous, active-high reset
//  Start      in   1     level; high = arm/restart program, falling edge = begin execution
//  Branch     in   1     absolute jump: PC <= Lut[PCTarg]
//  BranchEn   in   1     relative branch request, taken only if CondFlag=1
//  CondFlag   in   1     ALU condition (registered flag from previous instruction)
//  PCTarg     in   6     LUT index (absolute) or signed offset (relative)
//  Ack        in   1     current instruction is the halt opcode (all ones)
//  LutWrEn    in   1     write strobe for target LUT
//  LutWrAddr  in   6     LUT write index
//  LutWrData  in   PC_W  LUT write data
//  ProgCtr    out  PC_W  current instruction address
//  Running    out  1     high in RUN state
//  Done       out  1     high in HALT state
//  BrTaken    out  16    taken-branch count (BRANCH_STATS_EN only, else 0)
//  InstrCnt   out  16    retired-instruction count (BRANCH_STATS_EN only, else 0)
// BEHAVIOUR
//  - Reset: state=ARMED, ProgCtr=START_ADDR, Running=0, Done=0, counters=0; LUT contents unchanged.
//  - States: ARMED, RUN, HALT. Outputs Running/Done are decoded from the registered state.
//  - Start=1 in any state: next state=ARMED, ProgCtr<=START_ADDR, counters cleared.
//  - ARMED with Start=0: next state=RUN, ProgCtr holds START_ADDR. First instruction is fetched at START_ADDR.
//  - RUN, per-cycle PC update, priority order:
//    Reset > Start > Ack > Branch > (BranchEn & CondFlag) > increment.
//  - Ack=1 in RUN: next state=HALT, ProgCtr holds the halt address. Done=1 from the next cycle.
//  - Branch=1: ProgCtr <= Lut[PCTarg]. Overrides BranchEn when both are set.
//  - BranchEn=1 & CondFlag=1: ProgCtr <= ProgCtr + sext(PCTarg); offset range -32..+31.
//  - BranchEn=1 & CondFlag=0: ProgCtr <= ProgCtr + 1 (not taken).
//  - All PC arithmetic is modulo 2**PC_W. ProgCtr=max+1 wraps to 0, and a negative offset below 0 wraps high.
//  - HALT: ProgCtr frozen; Branch/BranchEn/Ack ignored; leaves only via Start or Reset.
//  - LUT: 1-cycle synchronous write and combinational read.
//  - LUT write-during-read to the same index: the jump uses the OLD entry; the new entry is visible next cycle.
//  - LUT writes are accepted in every state.
//  - Latency: a branch decision in cycle N sets ProgCtr in cycle N+1. No stalls, no bubbles.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//    InstrCnt increments once per RUN cycle.
//    BrTaken increments on each taken Branch or each (BranchEn & CondFlag).
//    Both saturate at 16'hFFFF and are cleared by Reset or Start.
//  BRANCH_STATS_EN undefined:
//    counter logic is absent; BrTaken and InstrCnt are driven constant 0.
//  No other behaviour differs between the two builds.
// TESTING
//  - Reset=1 for 2 cycles, then Start 1->0 -> ProgCtr=0; Running=1 one cycle after Start falls; ProgCtr then counts 0,1,2,3.
//  - Write Lut[5]=10'h1F0; at PC=3 drive Branch=1, PCTarg=5 -> ProgCtr=10'h1F0 next cycle.
//  - At PC=20 drive BranchEn=1, PCTarg=6'h3C (-4), CondFlag=1 -> PC=16.
//  - Repeat with CondFlag=0 -> PC=21.
//  - Relative wrap: at PC=10'h3FE, offset +3, CondFlag=1 -> PC=10'h001. At PC=1, offset -2 -> PC=10'h3FF.
//  - At PC=40 drive Ack=1 together with Branch=1 -> Done=1, ProgCtr stays 40, Branch ignored.
//    Start pulse then gives ARMED with PC=0, Done=0.
//  - BRANCH_STATS_EN: 10 RUN cycles containing 3 taken branches and 1 not-taken -> InstrCnt=10, BrTaken=3.
//    Start -> both counters 0.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: signal bundle between the control decoder / test driver and fetch_unit.
//   master : drives start, branch controls, halt ack and LUT write port; observes PC and status
//   slave  : fetch_unit side; consumes the controls and drives progctr, running, done, counters
interface fetch_if #(
    parameter int unsigned PC_W = 10
);
    localparam int unsigned TARG_W = 6;
    localparam int unsigned CNT_W  = 16;

    logic              start;
    logic              branch;
    logic              branchen;
    logic              condflag;
    logic [TARG_W-1:0] pctarg;
    logic              ack;
    logic              lutwren;
    logic [TARG_W-1:0] lutwraddr;
    logic [PC_W-1:0]   lutwrdata;
    logic [PC_W-1:0]   progctr;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  brtaken;
    logic [CNT_W-1:0]  instrcnt;

    modport master (
        output start, branch, branchen, condflag, pctarg, ack,
        output lutwren, lutwraddr, lutwrdata,
        input  progctr, running, done, brtaken, instrcnt
    );

    modport slave (
        input  start, branch, branchen, condflag, pctarg, ack,
        input  lutwren, lutwraddr, lutwrdata,
        output progctr, running, done, brtaken, instrcnt
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter / instruction-fetch stage with an ARMED/RUN/HALT program FSM.
//   clk   : system clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : fetch_if.slave
//     in  start, branch (absolute via LUT), branchen + condflag (relative), pctarg, ack (halt),
//         lutwren/lutwraddr/lutwrdata (target LUT write port)
//     out progctr, running, done, brtaken, instrcnt
// Optional build macro BRANCH_STATS_EN adds saturating retired-instruction and taken-branch
// counters; without it brtaken/instrcnt are tied to zero.
module fetch_unit #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned LUT_DEPTH  = 64
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.slave  bus
);
    localparam int unsigned TARG_W = 6;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic [PC_W-1:0] lut_rd_c;
    logic [PC_W-1:0] offset_c;

    // Target LUT: synchronous write, combinational read; no reset so contents survive Reset.
    // A same-cycle write and jump to one index sees the old entry.
    always_ff @(posedge clk) begin
        if (bus.lutwren) begin
            lut[bus.lutwraddr] <= bus.lutwrdata;
        end
    end

    always_comb begin
        lut_rd_c = lut[bus.pctarg];
        offset_c = {{(PC_W-TARG_W){bus.pctarg[TARG_W-1]}}, bus.pctarg};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED:   state_d = RUN;
                RUN:     if (bus.ack) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = ARMED;
            endcase
        end
    end

    // Output decode and next-PC selection; priority start > ack > branch > taken relative > increment
    always_comb begin
        pc_d        = pc_q;
        bus.running = (state_q == RUN);
        bus.done    = (state_q == HALT);
        if (bus.start) begin
            pc_d = PC_W'(START_ADDR);
        end else if (state_q == RUN) begin
            if (bus.ack) begin
                pc_d = pc_q;
            end else if (bus.branch) begin
                pc_d = lut_rd_c;
            end else if (bus.branchen && bus.condflag) begin
                pc_d = pc_q + offset_c;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_W'(START_ADDR);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.progctr = pc_q;

`ifdef BRANCH_STATS_EN
    logic             retire_c;
    logic             taken_c;
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] brtk_q;

    // A RUN cycle retires one instruction; the halt cycle counts but never branches
    always_comb begin
        retire_c = (state_q == RUN) && !bus.start;
        taken_c  = retire_c && !bus.ack && (bus.branch || (bus.branchen && bus.condflag));
    end

    // Saturating counters, cleared on reset or start
    always_ff @(posedge clk) begin
        if (reset || bus.start) begin
            instr_q <= '0;
            brtk_q  <= '0;
        end else begin
            if (retire_c && (instr_q != {CNT_W{1'b1}})) begin
                instr_q <= instr_q + CNT_W'(1);
            end
            if (taken_c && (brtk_q != {CNT_W{1'b1}})) begin
                brtk_q <= brtk_q + CNT_W'(1);
            end
        end
    end

    assign bus.instrcnt = instr_q;
    assign bus.brtaken  = brtk_q;
`else
    assign bus.instrcnt = '0;
    assign bus.brtaken  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit (default build or BRANCH_STATS_EN).
module tb_fetch_unit;
    localparam int unsigned PC_W = 10;

`ifdef BRANCH_STATS_EN
    localparam int unsigned EXP_IC = 10;
    localparam int unsigned EXP_BT = 3;
`else
    localparam int unsigned EXP_IC = 0;
    localparam int unsigned EXP_BT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    fetch_if #(.PC_W(PC_W)) bus ();

    fetch_unit #(
        .PC_W      (PC_W),
        .START_ADDR(0),
        .LUT_DEPTH (64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.start     = 1'b0;
        bus.branch    = 1'b0;
        bus.branchen  = 1'b0;
        bus.condflag  = 1'b0;
        bus.pctarg    = 6'h00;
        bus.ack       = 1'b0;
        bus.lutwren   = 1'b0;
        bus.lutwraddr = 6'h00;
        bus.lutwrdata = '0;
    endtask

    task automatic lut_wr(input logic [5:0] a, input logic [PC_W-1:0] d);
        bus.lutwren   = 1'b1;
        bus.lutwraddr = a;
        bus.lutwrdata = d;
        tick();
        bus.lutwren   = 1'b0;
    endtask

    task automatic jump(input logic [5:0] idx);
        bus.branch = 1'b1;
        bus.pctarg = idx;
        tick();
        bus.branch = 1'b0;
    endtask

    task automatic rel(input logic [5:0] off, input logic cf);
        bus.branchen = 1'b1;
        bus.condflag = cf;
        bus.pctarg   = off;
        tick();
        bus.branchen = 1'b0;
        bus.condflag = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_pc", 32'(bus.progctr), 32'h000);
        chk("rst_running", 32'(bus.running), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_instrcnt", 32'(bus.instrcnt), 32'd0);

        // Arm while loading branch targets
        reset     = 1'b0;
        bus.start = 1'b1;
        lut_wr(6'd5, 10'h1F0);
        lut_wr(6'd1, 10'h014);
        lut_wr(6'd2, 10'h3FE);
        lut_wr(6'd3, 10'h028);
        chk("armed_pc", 32'(bus.progctr), 32'h000);
        chk("armed_running", 32'(bus.running), 32'd0);

        // Start falls: RUN with PC at start address, then sequential fetch
        bus.start = 1'b0;
        tick();
        chk("run_running", 32'(bus.running), 32'd1);
        chk("run_pc0", 32'(bus.progctr), 32'h000);
        tick();
        chk("run_pc1", 32'(bus.progctr), 32'h001);
        tick();
        chk("run_pc2", 32'(bus.progctr), 32'h002);
        tick();
        chk("run_pc3", 32'(bus.progctr), 32'h003);

        jump(6'd5);
        chk("abs_jump", 32'(bus.progctr), 32'h1F0);

        // Jump while rewriting the same entry uses the old target
        bus.lutwren   = 1'b1;
        bus.lutwraddr = 6'd5;
        bus.lutwrdata = 10'h2AA;
        jump(6'd5);
        bus.lutwren   = 1'b0;
        chk("wdr_old", 32'(bus.progctr), 32'h1F0);
        jump(6'd5);
        chk("wdr_new", 32'(bus.progctr), 32'h2AA);

        // Branch wins over a simultaneously requested relative branch
        bus.branchen = 1'b1;
        bus.condflag = 1'b1;
        jump(6'd1);
        bus.branchen = 1'b0;
        bus.condflag = 1'b0;
        chk("abs_over_rel", 32'(bus.progctr), 32'h014);

        rel(6'h3C, 1'b1);
        chk("rel_taken_neg", 32'(bus.progctr), 32'h010);
        jump(6'd1);
        rel(6'h3C, 1'b0);
        chk("rel_not_taken", 32'(bus.progctr), 32'h015);

        // Modulo arithmetic in both directions
        jump(6'd2);
        chk("pc_3fe", 32'(bus.progctr), 32'h3FE);
        rel(6'h03, 1'b1);
        chk("rel_wrap_up", 32'(bus.progctr), 32'h001);
        rel(6'h3E, 1'b1);
        chk("rel_wrap_down", 32'(bus.progctr), 32'h3FF);
        tick();
        chk("inc_wrap", 32'(bus.progctr), 32'h000);

        // Halt takes priority over a branch; HALT then ignores controls
        jump(6'd3);
        chk("pc_40", 32'(bus.progctr), 32'h028);
        bus.ack    = 1'b1;
        bus.branch = 1'b1;
        bus.pctarg = 6'd5;
        tick();
        chk("halt_pc", 32'(bus.progctr), 32'h028);
        chk("halt_done", 32'(bus.done), 32'd1);
        chk("halt_running", 32'(bus.running), 32'd0);
        bus.branchen = 1'b1;
        bus.condflag = 1'b1;
        tick();
        chk("halt_frozen", 32'(bus.progctr), 32'h028);
        idle();
        lut_wr(6'd4, 10'h123);

        // Restart from HALT
        bus.start = 1'b1;
        tick();
        chk("restart_pc", 32'(bus.progctr), 32'h000);
        chk("restart_done", 32'(bus.done), 32'd0);
        chk("restart_running", 32'(bus.running), 32'd0);
        bus.start = 1'b0;
        tick();
        jump(6'd4);
        chk("halt_lut_write", 32'(bus.progctr), 32'h123);

        // Statistics window: 10 RUN cycles, 3 taken branches, 1 not-taken
        bus.start = 1'b1;
        tick();
        chk("clr_instrcnt", 32'(bus.instrcnt), 32'd0);
        chk("clr_brtaken", 32'(bus.brtaken), 32'd0);
        bus.start = 1'b0;
        tick();
        tick();
        jump(6'd1);
        rel(6'h01, 1'b1);
        rel(6'h01, 1'b0);
        chk("stats_pc", 32'(bus.progctr), 32'h016);
        tick();
        jump(6'd3);
        tick();
        tick();
        tick();
        tick();
        chk("stats_pc_end", 32'(bus.progctr), 32'h02C);
        chk("stats_instrcnt", 32'(bus.instrcnt), 32'(EXP_IC));
        chk("stats_brtaken", 32'(bus.brtaken), 32'(EXP_BT));
        bus.start = 1'b1;
        tick();
        chk("stats_clr_ic", 32'(bus.instrcnt), 32'd0);
        chk("stats_clr_bt", 32'(bus.brtaken), 32'd0);

        // Reset during RUN keeps LUT contents
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_pc", 32'(bus.progctr), 32'h000);
        chk("mid_rst_running", 32'(bus.running), 32'd0);
        reset = 1'b0;
        tick();
        jump(6'd4);
        chk("lut_after_rst", 32'(bus.progctr), 32'h123);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
